// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract scheduler: FSM encoding, nibble width, default width.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned NIB       = 4;
  localparam int unsigned WIDTH_DEF = 8;

endpackage

// File: rtl/addsub_nib.sv
// Combinational 4-bit add/subtract slice; b is inverted when sub is high, cin supplies the +1.
module addsub_nib
  import addsub_pkg::*;
(
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           sub,
  input  logic           cin,
  output logic [NIB-1:0] s,
  output logic           cout,
  output logic           c_msb_in
);

  logic [NIB-1:0] bx;
  logic [NIB-1:0] low;
  logic [1:0]     top;

  // Split at the MSB so the carry into it is visible for signed overflow.
  always_comb begin
    bx       = b ^ {NIB{sub}};
    low      = {1'b0, a[NIB-2:0]} + {1'b0, bx[NIB-2:0]} + {{(NIB-1){1'b0}}, cin};
    c_msb_in = low[NIB-1];
    top      = {1'b0, a[NIB-1]} + {1'b0, bx[NIB-1]} + {1'b0, c_msb_in};
    s        = {top[0], low[NIB-2:0]};
    cout     = top[1];
  end

endmodule

// File: rtl/addsub_sched.sv
// Round-robin two-requester scheduler over one shared nibble add/sub datapath.
// Optional signed overflow output enabled by defining ADDSUB_SCHED_OVF_EN.
module addsub_sched
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_ovf
);

  localparam int unsigned NPASS = WIDTH / NIB;
  localparam int unsigned KW    = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NPASS - 1);

  state_t           state;
  logic             lp;
  logic [KW-1:0]    k;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_q;

  logic             gnt0;
  logic             gnt1;
  logic             last;
  logic [NIB-1:0]   nib_s;
  logic             nib_cout;
  logic             nib_cmsb;

  // Readies are gated by rst so they read low while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && !rst) begin
      gnt0 = req0_valid && (!req1_valid || lp);
      gnt1 = req1_valid && (!req0_valid || !lp);
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign last       = (k == KLAST);

  addsub_nib u_nib (
    .a        (a_q[k*NIB +: NIB]),
    .b        (b_q[k*NIB +: NIB]),
    .sub      (sub_q),
    .cin      (carry),
    .s        (nib_s),
    .cout     (nib_cout),
    .c_msb_in (nib_cmsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lp        <= 1'b1;
      k         <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_s     <= '0;
      rsp_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            a_q    <= gnt1 ? req1_a   : req0_a;
            b_q    <= gnt1 ? req1_b   : req0_b;
            sub_q  <= gnt1 ? req1_sub : req0_sub;
            carry  <= gnt1 ? req1_sub : req0_sub;
            rsp_id <= gnt1;
            k      <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          rsp_s[k*NIB +: NIB] <= nib_s;
          carry               <= nib_cout;
          if (last) begin
            k         <= '0;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            lp        <= rsp_id;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADDSUB_SCHED_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state == CALC && last) begin
      ovf_q <= nib_cmsb ^ nib_cout;
    end
  end

  assign rsp_ovf = ovf_q;
`else
  logic unused_cmsb;
  assign unused_cmsb = nib_cmsb;
  assign rsp_ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_sched.sv
// Self-checking bench for addsub_sched against an integer-arithmetic reference model.
module tb_addsub_sched;

  localparam int unsigned W     = 8;
  localparam int unsigned NPASS = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_sub;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_sub;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_ovf;
  logic [W-1:0] rsp_s;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  addsub_sched #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_s      (rsp_s),
    .rsp_ovf    (rsp_ovf)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Signed-integer reference: result modulo 2^W, overflow when the true value leaves the signed range.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                output logic [W-1:0] s, output logic o);
    longint sa, sb, r, lim;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    r   = sub ? (sa - sb) : (sa + sb);
    lim = longint'(1) <<< (W - 1);
    s   = r[W-1:0];
    o   = (r > lim - 1) || (r < -lim);
`ifndef ADDSUB_SCHED_OVF_EN
    o   = 1'b0;
`endif
  endfunction

  // Issues one operation from a negedge, consumes the response, returns at a negedge.
  task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       output logic [W-1:0] s, output logic o, output logic rid,
                       output int lat, output bit tmo);
    int n;
    tmo = 0; n = 0; lat = 0; s = '0; o = 1'b0; rid = 1'b0;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub; end
    #1;
    while (((id ? req1_ready : req0_ready) !== 1'b1) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) begin
      tmo = 1; req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      return;
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk); lat++;
    end
    if (lat >= 20) tmo = 1;
    s = rsp_s; o = rsp_ovf; rid = rsp_id;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_s !== '0) begin errors++; $display("FAIL reset_rsp_s got %h want 00", rsp_s); end
    checks++; if (rsp_ovf !== 1'b0) begin errors++; $display("FAIL reset_rsp_ovf got %b want 0", rsp_ovf); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got %b want 0", rsp_id); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_readies got %b%b want 00", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic         ids [3] = '{1'b0, 1'b1, 1'b0};
    logic [W-1:0] as  [3] = '{8'h0F, 8'h80, 8'hFF};
    logic [W-1:0] bs  [3] = '{8'h01, 8'h01, 8'hFE};
    logic         sbs [3] = '{1'b0, 1'b1, 1'b1};
    logic [W-1:0] es  [3] = '{8'h10, 8'h7F, 8'h01};
    logic         eo  [3] = '{1'b0, 1'b1, 1'b0};
    logic [W-1:0] s; logic o, rid; int lat; bit tmo;
`ifndef ADDSUB_SCHED_OVF_EN
    eo = '{1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 3; i++) begin
      do_op(ids[i], as[i], bs[i], sbs[i], s, o, rid, lat, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL dir%0d_timeout", i); end
      checks++; if (s !== es[i]) begin errors++; $display("FAIL dir%0d_s got %h want %h", i, s, es[i]); end
      checks++; if (o !== eo[i]) begin errors++; $display("FAIL dir%0d_ovf got %b want %b", i, o, eo[i]); end
      checks++; if (rid !== ids[i]) begin errors++; $display("FAIL dir%0d_id got %b want %b", i, rid, ids[i]); end
      checks++; if (lat != int'(NPASS) + 1) begin
        errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, NPASS + 1);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, s, es; logic sub, id, o, eo, rid; int lat; bit tmo;
    for (int i = 0; i < 24; i++) begin
      id  = 1'($urandom);
      a   = W'($urandom);
      b   = W'($urandom);
      sub = 1'($urandom);
      model(a, b, sub, es, eo);
      do_op(id, a, b, sub, s, o, rid, lat, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL rnd%0d_timeout", i); end
      checks++; if (s !== es || o !== eo || rid !== id) begin
        errors++;
        $display("FAIL rnd%0d a=%h b=%h sub=%b got s=%h ovf=%b id=%b want s=%h ovf=%b id=%b",
                 i, a, b, sub, s, o, rid, es, eo, id);
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] a, b, es, hs, es1; logic sub, eo, ho, hi, eo1; int n;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    model(a, b, sub, es, eo);
    @(negedge clk);
    req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
    #1; n = 0;
    while (req0_ready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL stall_grant_timeout"); end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = W'($urandom); req1_b = W'($urandom); req1_sub = 1'($urandom);
    model(req1_a, req1_b, req1_sub, es1, eo1);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL stall_rsp_timeout"); end
    hs = rsp_s; ho = rsp_ovf; hi = rsp_id;
    checks++; if (hs !== es || ho !== eo || hi !== 1'b0) begin
      errors++; $display("FAIL stall_value got s=%h ovf=%b id=%b want s=%h ovf=%b id=0", hs, ho, hi, es, eo);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_s !== hs || rsp_ovf !== ho || rsp_id !== hi ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d got v=%b s=%h ovf=%b id=%b rdy=%b%b want v=1 s=%h ovf=%b id=%b rdy=00",
                 i, rsp_valid, rsp_s, rsp_ovf, rsp_id, req0_ready, req1_ready, hs, ho, hi);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release got v=%b req1_ready=%b want v=0 req1_ready=1", rsp_valid, req1_ready);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (n >= 20 || rsp_s !== es1 || rsp_ovf !== eo1 || rsp_id !== 1'b1) begin
      errors++; $display("FAIL stall_next got s=%h ovf=%b id=%b want s=%h ovf=%b id=1", rsp_s, rsp_ovf, rsp_id, es1, eo1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] s, es; logic o, eo, rid; int lat, n, seen; bit tmo;
    do_op(1'b0, W'($urandom), W'($urandom), 1'b0, s, o, rid, lat, tmo);
    req0_valid = 1'b1; req0_a = 8'h55; req0_b = 8'h22; req0_sub = 1'b0;
    #1; n = 0;
    while (req0_ready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL rstmid_grant_timeout"); end
    @(negedge clk);
    req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_after got v=%b rdy=%b%b want v=0 rdy=00", rsp_valid, req0_ready, req1_ready);
    end
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h3C; req0_b = 8'h41; req0_sub = 1'b1;
    req1_valid = 1'b1; req1_a = 8'h11; req1_b = 8'h22; req1_sub = 1'b0;
    model(8'h3C, 8'h41, 1'b1, es, eo);
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_dual_grant got rdy=%b%b want 10", req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (rsp_valid === 1'b1) begin
        seen++;
        checks++; if (rsp_s !== es || rsp_ovf !== eo || rsp_id !== 1'b0) begin
          errors++; $display("FAIL rstmid_rsp got s=%h ovf=%b id=%b want s=%h ovf=%b id=0", rsp_s, rsp_ovf, rsp_id, es, eo);
        end
        rsp_ready = 1'b1;
      end
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    checks++; if (seen != 1) begin errors++; $display("FAIL rstmid_rsp_count got %0d want 1", seen); end
  endtask

  typedef struct { logic id; logic [W-1:0] s; logic o; } exp_t;

  task automatic test_back_to_back();
    exp_t q[$];
    exp_t e;
    int got, last_cyc, n;
    logic [W-1:0] es; logic eo;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = W'($urandom); req0_b = W'($urandom); req0_sub = 1'($urandom);
    req1_valid = 1'b1; req1_a = W'($urandom); req1_b = W'($urandom); req1_sub = 1'($urandom);
    got = 0; last_cyc = -1; n = 0;
    while (got < 6 && n < 100) begin
      #1;
      checks++; if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
        errors++; $display("FAIL b2b_two_readies at cycle %0d got 11 want at most one", cyc);
      end
      if (rsp_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected_rsp got id=%b want none", rsp_id);
        end else begin
          e = q.pop_front();
          if (rsp_id !== 1'(got % 2) || rsp_s !== e.s || rsp_ovf !== e.o) begin
            errors++;
            $display("FAIL b2b_rsp%0d got id=%b s=%h ovf=%b want id=%0d s=%h ovf=%b",
                     got, rsp_id, rsp_s, rsp_ovf, got % 2, e.s, e.o);
          end
        end
        if (last_cyc >= 0) begin
          checks++; if (cyc - last_cyc != int'(NPASS) + 2) begin
            errors++; $display("FAIL b2b_period got %0d want %0d", cyc - last_cyc, NPASS + 2);
          end
        end
        last_cyc = cyc;
        got++;
        if (got == 6) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      end
      if (req0_ready === 1'b1) begin
        model(req0_a, req0_b, req0_sub, es, eo);
        q.push_back('{1'b0, es, eo});
        @(posedge clk); #1;
        req0_a = W'($urandom); req0_b = W'($urandom); req0_sub = 1'($urandom);
      end else if (req1_ready === 1'b1) begin
        model(req1_a, req1_b, req1_sub, es, eo);
        q.push_back('{1'b1, es, eo});
        @(posedge clk); #1;
        req1_a = W'($urandom); req1_b = W'($urandom); req1_sub = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    checks++; if (got != 6) begin errors++; $display("FAIL b2b_count got %0d want 6", got); end
    rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_sched.md
# addsub_sched

Two-requester scheduler that shares one 4-bit add/subtract nibble datapath. It arbitrates round-robin between two requesters and executes WIDTH-bit add or subtract operations as WIDTH/4 sequential nibble passes with carry chaining. Each result is returned with a signed overflow flag. It sits between client blocks and the single ripple adder/inverter datapath, so that datapath is never duplicated.

## Interface
- WIDTH, 8, operand/result width; must be a multiple of 4 and at least 4
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  WIDTH each  operands, two's complement
- req0_sub  in  1  1 = a-b, 0 = a+b
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same meanings for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  index of the requester that owns the result
- rsp_s  out  WIDTH  sum/difference, modulo 2^WIDTH
- rsp_ovf  out  1  signed overflow of the full WIDTH-bit operation

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - Grant goes to the requester with valid high.
  - If both are valid, grant goes to the one not granted last, tracked by pointer lp.
  - The granted reqN_ready is high combinationally in that cycle. Operands, sub, and id are latched.
  - Carry is initialised to sub. Pass counter k is set to 0. Next state is CALC.
- **CALC**
  - Each cycle computes s[4k+3:4k] = a_nib + (b_nib XOR {4{sub}}) + carry, then registers carry-out and k+1.
  - On the last pass (k = WIDTH/4-1), ovf = carry into MSB XOR carry out of MSB, and the FSM goes to DONE.
- **DONE**
  - rsp_valid is high, and rsp_s, rsp_ovf, and rsp_id are stable.
  - On rsp_ready, the FSM goes to IDLE and lp is set to rsp_id.
- Both readies are low outside IDLE, so at most one ready is high in any cycle.
- Requesters hold valid and operands stable until ready. The block does not check this.
- Reset values:
  - state = IDLE, lp = 1 (req0 wins the first contest), k = 0, carry = 0
  - rsp_valid = 0, rsp_s = 0, rsp_ovf = 0, rsp_id = 0, req0_ready = req1_ready = 0.
- Reset mid-operation: the in-flight operation is discarded and no response is produced. The next cycle is IDLE with reset values.

## Timing
- Accept at cycle T. Passes occur at T+1 … T+WIDTH/4. rsp_valid rises at T+WIDTH/4+1.
- For WIDTH=8, rsp_valid rises at T+3. For WIDTH=4 (single pass), it rises at T+2.
- If rsp_ready is high in the first DONE cycle, the FSM returns to IDLE the next cycle. The earliest next accept is then, with no bypass.
- Peak throughput is one operation per WIDTH/4+2 cycles.
- rsp_ready held low: DONE persists indefinitely and outputs do not change.
- A requester whose valid drops in a cycle where it is not granted loses nothing; no state is kept for it.

## Configuration
- ADDSUB_SCHED_OVF_EN defined: overflow is computed as described, and rsp_ovf carries it.
- Not defined: the overflow register and logic are removed, and rsp_ovf is tied to 0. Sums and timing are unchanged.

## Structure
- Shared package addsub_pkg holds:
  - the state encoding constants (IDLE=2'd0, CALC=2'd1, DONE=2'd2)
  - the nibble width constant (4)
  - the default WIDTH
- One sub-module, addsub_nib: combinational 4-bit add/subtract with inputs a, b, sub, cin and outputs s, cout, c_msb_in. It inverts b internally when sub is high.
- The scheduler instantiates exactly one addsub_nib.

## Test plan
WIDTH=8 and ADDSUB_SCHED_OVF_EN defined unless noted.
- req0 a=0x0F, b=0x01, sub=0 → rsp_s=0x10, ovf=0, id=0, rsp_valid exactly 3 cycles after req0_ready.
- req1 a=0x80, b=0x01, sub=1 → rsp_s=0x7F, ovf=1, id=1.
- req0 a=0xFF, b=0xFE, sub=1 → rsp_s=0x01, ovf=0. Same stimulus with the macro undefined → rsp_ovf=0, rsp_s=0x01.
- Both valid continuously from reset, rsp_ready=1 → rsp_id sequence 0,1,0,1 and never two readies in one cycle.
- rsp_ready low for 5 cycles in DONE → rsp_s, rsp_ovf, rsp_id, rsp_valid all stable and both readies low; release → IDLE next cycle.
- rst pulsed during CALC pass 0 → next cycle rsp_valid=0, no response for that operation, and a subsequent dual request is granted to req0.
